mousetrap_sync_sink: RTL and testbench

//  Clocked receiver at the tail of a MouseTrap asynchronous pipeline.
//  - Accepts 2-phase bundled-data tokens (req_in toggle + data_in) from the last latch stage.
//  - Buffers them in a small FIFO and presents them as a valid/ready stream to synchronous logic.
//  - Returns a 2-phase ack_out toggle per accepted token, closing the last stage's handshake.

---
 rtl/mt_pkg.sv | 16 +
 rtl/mt_toggle_sync.sv | 36 +++
 rtl/mousetrap_sync_sink.sv | 108 ++++++++++
 tb/tb_mousetrap_sync_sink.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mt_pkg.sv
// Shared types and defaults for the MouseTrap synchronous sink.
//   phase_t            : 2-phase handshake level
//   sink_state_t       : sink FSM states (WAIT, HOLD)
//   MT_SYNC_STAGES_DEF : default depth of the req synchronizer
package mt_pkg;

    typedef logic phase_t;

    typedef enum logic {
        WAIT = 1'b0,
        HOLD = 1'b1
    } sink_state_t;

    localparam int MT_SYNC_STAGES_DEF = 2;

endpackage

// File: rtl/mt_toggle_sync.sv
// Synchronizes an asynchronous 2-phase request into the clock domain and
// keeps the last consumed phase, flagging a new token while they differ.
// Ports:
//   clk_i     in   clock
//   rst_i     in   synchronous active-high reset
//   req_i     in   2-phase request, asynchronous to clk_i
//   consume   in   token taken this cycle: flips the seen phase
//   pending   out  synchronized phase differs from the seen phase
module mt_toggle_sync
    import mt_pkg::*;
#(
    parameter int SYNC_STAGES = MT_SYNC_STAGES_DEF
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic req_i,
    input  logic consume,
    output logic pending
);

    logic [SYNC_STAGES-1:0] sync_q;
    phase_t                 seen_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q <= '0;
            seen_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], req_i};
            if (consume) seen_q <= ~seen_q;
        end
    end

    assign pending = sync_q[SYNC_STAGES-1] ^ seen_q;

endmodule

// File: rtl/mousetrap_sync_sink.sv
// Clocked receiver at the tail of a MouseTrap asynchronous pipeline.
// 2-phase bundled-data tokens are buffered in a small FIFO, offered as a
// valid/ready stream, and acknowledged with a registered 2-phase toggle.
// Optional feature macro: MT_SINK_COUNT_EN adds the 32-bit token_count port.
// Ports:
//   Clk          in   clock
//   extReset     in   synchronous active-high reset
//   req_in       in   2-phase request from last stage (async)
//   data_in      in   bundled data, stable until matching ack_out edge
//   ack_out      out  2-phase acknowledge (registered)
//   out_valid    out  FIFO non-empty
//   out_ready    in   consumer takes head this cycle
//   out_data     out  FIFO head
//   token_count  out  accepted-token counter (MT_SINK_COUNT_EN only)
module mousetrap_sync_sink
    import mt_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = MT_SYNC_STAGES_DEF,
    parameter int DEPTH       = 2
) (
    input  logic             Clk,
    input  logic             extReset,
    input  logic             req_in,
    input  logic [WIDTH-1:0] data_in,
    output logic             ack_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
`ifdef MT_SINK_COUNT_EN
    ,
    output logic [31:0]      token_count
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    phase_t           ack_q;
    sink_state_t      state_q;
    logic             pending, full, push, pop;

    mt_toggle_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk_i   (Clk),
        .rst_i   (extReset),
        .req_i   (req_in),
        .consume (push),
        .pending (pending)
    );

    // full is the registered (pre-pop) occupancy, so a pop in the same
    // cycle never frees room for a push; the held token goes next cycle.
    assign full      = (count_q == CNT_W'(DEPTH));
    assign push      = pending && !full;
    assign pop       = out_valid && out_ready;
    assign out_valid = (count_q != '0);
    assign out_data  = mem_q[rd_ptr_q];
    assign ack_out   = ack_q;

    always_ff @(posedge Clk) begin
        if (extReset) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ack_q    <= 1'b0;
            state_q  <= WAIT;
        end else begin
            // Sink FSM: HOLD marks a token seen while the FIFO had no room.
            case (state_q)
                WAIT:    if (pending && full) state_q <= HOLD;
                HOLD:    if (!full)           state_q <= WAIT;
                default:                      state_q <= WAIT;
            endcase

            // Capture and acknowledge on the same edge.
            if (push) begin
                mem_q[wr_ptr_q] <= data_in;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
                ack_q           <= ~ack_q;
            end
            if (pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);

            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

`ifdef MT_SINK_COUNT_EN
    logic [31:0] tok_cnt_q;

    always_ff @(posedge Clk) begin
        if (extReset)  tok_cnt_q <= '0;
        else if (push) tok_cnt_q <= tok_cnt_q + 32'd1;
    end

    assign token_count = tok_cnt_q;
`endif

endmodule

// File: tb/tb_mousetrap_sync_sink.sv
module tb_mousetrap_sync_sink;

    logic       Clk = 1'b0;
    logic       extReset;
    logic       req_in;
    logic [7:0] data_in;
    logic       ack_out;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
`ifdef MT_SINK_COUNT_EN
    logic [31:0] token_count;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 Clk = ~Clk;

    mousetrap_sync_sink #(.WIDTH(8), .SYNC_STAGES(2), .DEPTH(2)) dut (
        .Clk       (Clk),
        .extReset  (extReset),
        .req_in    (req_in),
        .data_in   (data_in),
        .ack_out   (ack_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
`ifdef MT_SINK_COUNT_EN
        ,
        .token_count (token_count)
`endif
    );

    // Advance one clock; inputs driven and outputs sampled 1 time unit later.
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Upstream stage: launch a token and wait (bounded) for its acknowledge.
    task automatic send(input logic [7:0] d);
        int n = 0;
        data_in = d;
        req_in  = ~req_in;
        while (ack_out !== req_in && n < 20) begin
            tick();
            n++;
        end
        n_tests++;
        if (ack_out !== req_in) begin
            n_fail++;
            $display("FAIL send_ack_timeout: ack_out=%b req_in=%b data=%h", ack_out, req_in, d);
        end
    endtask

    task automatic test_reset();
        extReset  = 1'b1;
        req_in    = 1'b0;
        data_in   = 8'h00;
        out_ready = 1'b0;
        repeat (3) tick();
        n_tests++;
        if (ack_out !== 1'b0) begin n_fail++; $display("FAIL reset_ack: got %b exp 0", ack_out); end
        n_tests++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b exp 0", out_valid); end
        n_tests++;
        if (out_data !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h exp 00", out_data); end
`ifdef MT_SINK_COUNT_EN
        n_tests++;
        if (token_count !== 32'd0) begin n_fail++; $display("FAIL reset_count: got %h exp 0", token_count); end
`endif
        extReset = 1'b0;
        tick();
    endtask

    // Latency: 3 edges from req toggle to valid/ack (2 sync flops + capture).
    task automatic test_single();
        out_ready = 1'b0;
        data_in   = 8'hA5;
        req_in    = ~req_in;
        repeat (2) tick();
        n_tests++;
        if (out_valid !== 1'b0 || ack_out !== 1'b0) begin
            n_fail++; $display("FAIL single_early: valid=%b ack=%b exp 0 0", out_valid, ack_out);
        end
        tick();
        n_tests++;
        if (out_valid !== 1'b1 || ack_out !== 1'b1) begin
            n_fail++; $display("FAIL single_latency: valid=%b ack=%b exp 1 1", out_valid, ack_out);
        end
        n_tests++;
        if (out_data !== 8'hA5) begin n_fail++; $display("FAIL single_data: got %h exp a5", out_data); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        n_tests++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_pop: valid=%b exp 0", out_valid); end
    endtask

    task automatic test_backpressure();
        logic [7:0] exp [2];
        exp[0] = 8'h02;
        exp[1] = 8'h03;
        out_ready = 1'b0;
        send(8'h01);
        send(8'h02);
        data_in = 8'h03;
        req_in  = ~req_in;
        repeat (6) tick();
        n_tests++;
        if (ack_out === req_in) begin n_fail++; $display("FAIL bp_hold_ack: ack=%b should differ from req=%b", ack_out, req_in); end
        n_tests++;
        if (out_data !== 8'h01) begin n_fail++; $display("FAIL bp_head: got %h exp 01", out_data); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        n_tests++;
        if (ack_out === req_in) begin n_fail++; $display("FAIL bp_ack_same_cycle: ack=%b req=%b", ack_out, req_in); end
        tick();
        n_tests++;
        if (ack_out !== req_in) begin n_fail++; $display("FAIL bp_ack_next: ack=%b exp %b", ack_out, req_in); end
        for (int i = 0; i < 2; i++) begin
            n_tests++;
            if (out_valid !== 1'b1 || out_data !== exp[i]) begin
                n_fail++; $display("FAIL bp_drain%0d: valid=%b data=%h exp 1 %h", i, out_valid, out_data, exp[i]);
            end
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
        end
        n_tests++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_empty: valid=%b exp 0", out_valid); end
    endtask

    task automatic test_full_push_pop();
        out_ready = 1'b0;
        send(8'hAA);
        send(8'hBB);
        data_in = 8'hCC;
        req_in  = ~req_in;
        repeat (4) tick();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        n_tests++;
        if (ack_out === req_in || out_data !== 8'hBB) begin
            n_fail++; $display("FAIL fpp_blocked: ack=%b req=%b data=%h exp data bb", ack_out, req_in, out_data);
        end
        tick();
        n_tests++;
        if (ack_out !== req_in) begin n_fail++; $display("FAIL fpp_push_next: ack=%b exp %b", ack_out, req_in); end
        out_ready = 1'b1;
        tick();
        n_tests++;
        if (out_data !== 8'hCC) begin n_fail++; $display("FAIL fpp_order: got %h exp cc", out_data); end
        tick();
        out_ready = 1'b0;
        n_tests++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL fpp_empty: valid=%b exp 0", out_valid); end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        send(8'h11);
        data_in = 8'h22;
        req_in  = ~req_in;
        tick();
        extReset = 1'b1;
        req_in   = 1'b0;
        repeat (2) tick();
        n_tests++;
        if (out_valid !== 1'b0 || ack_out !== 1'b0) begin
            n_fail++; $display("FAIL rmid_state: valid=%b ack=%b exp 0 0", out_valid, ack_out);
        end
        extReset = 1'b0;
        repeat (3) tick();
        n_tests++;
        if (out_valid !== 1'b0 || ack_out !== 1'b0) begin
            n_fail++; $display("FAIL rmid_no_ghost: valid=%b ack=%b exp 0 0", out_valid, ack_out);
        end
        send(8'h33);
        n_tests++;
        if (out_valid !== 1'b1 || out_data !== 8'h33) begin
            n_fail++; $display("FAIL rmid_new: valid=%b data=%h exp 1 33", out_valid, out_data);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    // Random traffic against a queue model of the FIFO contents.
    task automatic test_random();
        logic [7:0] exp_q [$];
        logic [7:0] tok = 8'h00;
        logic [7:0] d;
        logic       v, r, in_flight;
        int         age;
        in_flight = 1'b0;
        age       = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (!in_flight && ($urandom_range(0, 2) != 0)) begin
                tok       = 8'($urandom);
                data_in   = tok;
                req_in    = ~req_in;
                in_flight = 1'b1;
                age       = 0;
            end
            r = 1'($urandom_range(0, 1));
            out_ready = r;
            v = out_valid;
            d = out_data;
            tick();
            if (r && v) begin
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++; $display("FAIL rnd_pop_empty: popped %h with empty model", d);
                end else begin
                    logic [7:0] e;
                    e = exp_q.pop_front();
                    if (d !== e) begin n_fail++; $display("FAIL rnd_pop_data: got %h exp %h", d, e); end
                end
            end
            if (in_flight && ack_out === req_in) begin
                exp_q.push_back(tok);
                in_flight = 1'b0;
            end else if (!in_flight && ack_out !== req_in) begin
                n_tests++;
                n_fail++; $display("FAIL rnd_spurious_ack: ack=%b req=%b", ack_out, req_in);
            end
            if (in_flight) age++;
            n_tests++;
            if (age > 40 || exp_q.size() > 2) begin
                n_fail++; $display("FAIL rnd_progress: age=%0d model_size=%0d", age, exp_q.size());
                age = 0;
            end
            n_tests++;
            if (out_valid !== (exp_q.size() != 0)) begin
                n_fail++; $display("FAIL rnd_valid: got %b exp %b", out_valid, exp_q.size() != 0);
            end else if (exp_q.size() != 0 && out_data !== exp_q[0]) begin
                n_fail++; $display("FAIL rnd_head: got %h exp %h", out_data, exp_q[0]);
            end
        end
        // Let any outstanding token land, then drain.
        out_ready = 1'b1;
        repeat (10) tick();
        out_ready = 1'b0;
        n_tests++;
        if (out_valid !== 1'b0 || ack_out !== req_in) begin
            n_fail++; $display("FAIL rnd_drain: valid=%b ack=%b req=%b", out_valid, ack_out, req_in);
        end
    endtask

`ifdef MT_SINK_COUNT_EN
    task automatic test_count();
        extReset = 1'b1;
        req_in   = 1'b0;
        tick();
        extReset = 1'b0;
        tick();
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) send(8'(i + 1));
        n_tests++;
        if (token_count !== 32'd5) begin n_fail++; $display("FAIL count_5: got %0d exp 5", token_count); end
        force dut.tok_cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.tok_cnt_q;
        n_tests++;
        if (token_count !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL count_preload: got %h exp ffffffff", token_count); end
        send(8'h77);
        n_tests++;
        if (token_count !== 32'd0) begin n_fail++; $display("FAIL count_wrap: got %h exp 0", token_count); end
        tick();
        out_ready = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_backpressure();
        test_full_push_pop();
        test_reset_mid();
        test_random();
`ifdef MT_SINK_COUNT_EN
        test_count();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
